// File: rtl/crop_gauss_pkg.sv
// Shared types and constants for the crop + Gaussian-spot estimator.
package crop_gauss_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCoord,
        StStream,
        StEmit
    } state_e;

    // 2^12 exceeds the 48x48 window pixel count, so a full window sum cannot overflow.
    localparam int unsigned ACC_GUARD_BITS = 12;

    localparam int unsigned NUM_OUT = 5;
    localparam int unsigned OUT_AMP = 0;
    localparam int unsigned OUT_COL = 1;
    localparam int unsigned OUT_ROW = 2;
    localparam int unsigned OUT_BG  = 3;
    localparam int unsigned OUT_SUM = 4;

    // Largest positive value of a signed word of the given width.
    function automatic int signed sat_hi(input int unsigned width);
        return (2 ** (width - 1)) - 1;
    endfunction

endpackage

// File: rtl/axis_hold_reg.sv
// Single-entry valid/ready holding register: load sets valid, a handshake clears it.
module axis_hold_reg #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] load_data,
    output logic [Width-1:0] tdata,
    output logic             tvalid,
    input  logic             tready
);

    logic [Width-1:0] data_q;
    logic             valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= load_data;
            valid_q <= 1'b1;
        end else if (valid_q && tready) begin
            valid_q <= 1'b0;
        end
    end

    assign tdata  = data_q;
    assign tvalid = valid_q;

endmodule

// File: rtl/crop_plus_gaussian.sv
// Streaming ROI crop feeding a Gaussian-spot estimator: window max with its position,
// window min and a scaled window sum, each returned on its own stream.
module crop_plus_gaussian
    import crop_gauss_pkg::*;
#(
    parameter int unsigned PIXEL_BIT_WIDTH  = 16,
    parameter int unsigned IN_ROWS          = 100,
    parameter int unsigned IN_COLS          = 160,
    parameter int unsigned OUT_ROWS         = 48,
    parameter int unsigned OUT_COLS         = 48,
    parameter int unsigned IMG_ROW_BITWIDTH = 10,
    parameter int unsigned IMG_COL_BITWIDTH = 10,
    parameter int unsigned SUM_SHIFT        = 12
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    input  logic                        ap_start,
    output logic                        ap_done,
    output logic                        ap_idle,
    output logic                        ap_ready,
    input  logic [PIXEL_BIT_WIDTH-1:0]  img_input_TDATA,
    input  logic                        img_input_TVALID,
    output logic                        img_input_TREADY,
    input  logic [IMG_ROW_BITWIDTH-1:0] crop_Y1_TDATA,
    input  logic                        crop_Y1_TVALID,
    output logic                        crop_Y1_TREADY,
    input  logic [IMG_COL_BITWIDTH-1:0] crop_X1_TDATA,
    input  logic                        crop_X1_TVALID,
    output logic                        crop_X1_TREADY,
    output logic [PIXEL_BIT_WIDTH-1:0]  cnn_output_0_TDATA,
    output logic                        cnn_output_0_TVALID,
    input  logic                        cnn_output_0_TREADY,
    output logic [PIXEL_BIT_WIDTH-1:0]  cnn_output_1_TDATA,
    output logic                        cnn_output_1_TVALID,
    input  logic                        cnn_output_1_TREADY,
    output logic [PIXEL_BIT_WIDTH-1:0]  cnn_output_2_TDATA,
    output logic                        cnn_output_2_TVALID,
    input  logic                        cnn_output_2_TREADY,
    output logic [PIXEL_BIT_WIDTH-1:0]  cnn_output_3_TDATA,
    output logic                        cnn_output_3_TVALID,
    input  logic                        cnn_output_3_TREADY,
    output logic [PIXEL_BIT_WIDTH-1:0]  cnn_output_4_TDATA,
    output logic                        cnn_output_4_TVALID,
    input  logic                        cnn_output_4_TREADY
);

    localparam int unsigned PW   = PIXEL_BIT_WIDTH;
    localparam int unsigned RW   = IMG_ROW_BITWIDTH;
    localparam int unsigned CW   = IMG_COL_BITWIDTH;
    localparam int unsigned SumW = PW + ACC_GUARD_BITS;

    localparam logic [RW-1:0] Y1Max   = RW'(IN_ROWS - OUT_ROWS);
    localparam logic [CW-1:0] X1Max   = CW'(IN_COLS - OUT_COLS);
    localparam logic [RW-1:0] LastRow = RW'(IN_ROWS - 1);
    localparam logic [CW-1:0] LastCol = CW'(IN_COLS - 1);
    localparam logic signed [SumW-1:0] SatHi = SumW'(sat_hi(PW));
    localparam logic signed [SumW-1:0] SatLo = ~SatHi;

    state_e state_q, state_d;

    logic [RW-1:0]          y1_q, row_q, max_row_q, max_row_d, rel_row;
    logic [CW-1:0]          x1_q, col_q, max_col_q, max_col_d, rel_col;
    logic                   y1_got_q, x1_got_q, seen_q;
    logic signed [PW-1:0]   pix, max_q, max_d, min_q, min_d;
    logic signed [SumW-1:0] sum_q, sum_d, sum_sh;
    logic                   start, y1_fire, x1_fire, pix_fire, last_pix, in_win;
    logic                   emit_load, all_drain;
    logic [PW-1:0]          res      [NUM_OUT];
    logic [PW-1:0]          out_data [NUM_OUT];
    logic [NUM_OUT-1:0]     out_valid, out_ready;

    assign start            = (state_q == StIdle) && ap_start;
    assign crop_Y1_TREADY   = (state_q == StCoord) && !y1_got_q;
    assign crop_X1_TREADY   = (state_q == StCoord) && !x1_got_q;
    assign y1_fire          = crop_Y1_TVALID && crop_Y1_TREADY;
    assign x1_fire          = crop_X1_TVALID && crop_X1_TREADY;
    assign img_input_TREADY = (state_q == StStream);
    assign pix_fire         = img_input_TVALID && img_input_TREADY;
    assign pix              = img_input_TDATA;
    assign last_pix         = (row_q == LastRow) && (col_q == LastCol);

    // Subtract-then-compare avoids overflowing y1 + OUT_ROWS.
    assign rel_row = row_q - y1_q;
    assign rel_col = col_q - x1_q;
    assign in_win  = (row_q >= y1_q) && (rel_row < RW'(OUT_ROWS)) &&
                     (col_q >= x1_q) && (rel_col < CW'(OUT_COLS));

    assign emit_load = pix_fire && last_pix;
    assign all_drain = &(~out_valid | out_ready);
    assign ap_ready  = emit_load;
    assign ap_idle   = (state_q == StIdle);
    assign ap_done   = (state_q == StEmit) && all_drain;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (ap_start) state_d = StCoord;
            StCoord:  if ((y1_got_q || y1_fire) && (x1_got_q || x1_fire)) state_d = StStream;
            StStream: if (emit_load) state_d = StEmit;
            StEmit:   if (all_drain) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Strict compares keep the first extreme in raster order.
    always_comb begin
        max_d     = max_q;
        min_d     = min_q;
        max_row_d = max_row_q;
        max_col_d = max_col_q;
        sum_d     = sum_q;
        if (pix_fire && in_win) begin
            if (!seen_q || pix > max_q) begin
                max_d     = pix;
                max_row_d = rel_row;
                max_col_d = rel_col;
            end
            if (!seen_q || pix < min_q) min_d = pix;
            sum_d = sum_q + SumW'(pix);
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            y1_q      <= '0;
            x1_q      <= '0;
            y1_got_q  <= 1'b0;
            x1_got_q  <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            seen_q    <= 1'b0;
            max_q     <= '0;
            min_q     <= '0;
            max_row_q <= '0;
            max_col_q <= '0;
            sum_q     <= '0;
        end else if (start) begin
            y1_got_q  <= 1'b0;
            x1_got_q  <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            seen_q    <= 1'b0;
            max_q     <= '0;
            min_q     <= '0;
            max_row_q <= '0;
            max_col_q <= '0;
            sum_q     <= '0;
        end else begin
            if (y1_fire) begin
                y1_q     <= (crop_Y1_TDATA > Y1Max) ? Y1Max : crop_Y1_TDATA;
                y1_got_q <= 1'b1;
            end
            if (x1_fire) begin
                x1_q     <= (crop_X1_TDATA > X1Max) ? X1Max : crop_X1_TDATA;
                x1_got_q <= 1'b1;
            end
            if (pix_fire) begin
                col_q <= (col_q == LastCol) ? '0 : col_q + CW'(1);
                if (col_q == LastCol) row_q <= row_q + RW'(1);
                if (in_win) seen_q <= 1'b1;
            end
            max_q     <= max_d;
            min_q     <= min_d;
            max_row_q <= max_row_d;
            max_col_q <= max_col_d;
            sum_q     <= sum_d;
        end
    end

    // Results are taken from next-state values so the last pixel is included.
    assign sum_sh = sum_d >>> SUM_SHIFT;

    always_comb begin
        res[OUT_AMP] = max_d;
        res[OUT_COL] = PW'(max_col_d);
        res[OUT_ROW] = PW'(max_row_d);
        res[OUT_BG]  = min_d;
        res[OUT_SUM] = sum_sh[PW-1:0];
        if (sum_sh > SatHi) begin
            res[OUT_SUM] = PW'(SatHi);
        end else if (sum_sh < SatLo) begin
            res[OUT_SUM] = PW'(SatLo);
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
        axis_hold_reg #(
            .Width(PW)
        ) u_hold (
            .clk      (ap_clk),
            .rst      (ap_rst),
            .load     (emit_load),
            .load_data(res[k]),
            .tdata    (out_data[k]),
            .tvalid   (out_valid[k]),
            .tready   (out_ready[k])
        );
    end

    assign out_ready = {cnn_output_4_TREADY, cnn_output_3_TREADY, cnn_output_2_TREADY,
                        cnn_output_1_TREADY, cnn_output_0_TREADY};

    assign cnn_output_0_TDATA  = out_data[0];
    assign cnn_output_1_TDATA  = out_data[1];
    assign cnn_output_2_TDATA  = out_data[2];
    assign cnn_output_3_TDATA  = out_data[3];
    assign cnn_output_4_TDATA  = out_data[4];
    assign cnn_output_0_TVALID = out_valid[0];
    assign cnn_output_1_TVALID = out_valid[1];
    assign cnn_output_2_TVALID = out_valid[2];
    assign cnn_output_3_TVALID = out_valid[3];
    assign cnn_output_4_TVALID = out_valid[4];

endmodule

// File: tb/tb_crop_plus_gaussian.sv
// Directed bench for crop_plus_gaussian: fixed images with hand-computed spot parameters.
module tb_crop_plus_gaussian;

    logic        ap_clk = 1'b0;
    logic        ap_rst, ap_start;
    logic        ap_done, ap_idle, ap_ready;
    logic [15:0] img_input_TDATA;
    logic        img_input_TVALID, img_input_TREADY;
    logic [9:0]  crop_Y1_TDATA, crop_X1_TDATA;
    logic        crop_Y1_TVALID, crop_Y1_TREADY, crop_X1_TVALID, crop_X1_TREADY;
    logic [15:0] out_data [5];
    logic [4:0]  out_valid, out_ready;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] got_data [5];
    int          acc_cnt [5];
    int          ready_cnt, done_cnt, timeouts, stab_err;
    logic [4:0]  post_valid;
    logic        post_idle;

    logic [15:0] exp_basic [5] = '{16'd9177, 16'd47, 16'd47, 16'd1610, 16'd3033};
    logic [15:0] exp_clamp [5] = '{16'd15999, 16'd47, 16'd47, 16'd8432, 16'd6871};
    logic [15:0] exp_const [5] = '{16'hFFFF, 16'd0, 16'd0, 16'hFFFF, 16'hFFFF};

    always #5 ap_clk = ~ap_clk;

    crop_plus_gaussian dut (
        .ap_clk             (ap_clk),
        .ap_rst             (ap_rst),
        .ap_start           (ap_start),
        .ap_done            (ap_done),
        .ap_idle            (ap_idle),
        .ap_ready           (ap_ready),
        .img_input_TDATA    (img_input_TDATA),
        .img_input_TVALID   (img_input_TVALID),
        .img_input_TREADY   (img_input_TREADY),
        .crop_Y1_TDATA      (crop_Y1_TDATA),
        .crop_Y1_TVALID     (crop_Y1_TVALID),
        .crop_Y1_TREADY     (crop_Y1_TREADY),
        .crop_X1_TDATA      (crop_X1_TDATA),
        .crop_X1_TVALID     (crop_X1_TVALID),
        .crop_X1_TREADY     (crop_X1_TREADY),
        .cnn_output_0_TDATA (out_data[0]),
        .cnn_output_0_TVALID(out_valid[0]),
        .cnn_output_0_TREADY(out_ready[0]),
        .cnn_output_1_TDATA (out_data[1]),
        .cnn_output_1_TVALID(out_valid[1]),
        .cnn_output_1_TREADY(out_ready[1]),
        .cnn_output_2_TDATA (out_data[2]),
        .cnn_output_2_TVALID(out_valid[2]),
        .cnn_output_2_TREADY(out_ready[2]),
        .cnn_output_3_TDATA (out_data[3]),
        .cnn_output_3_TVALID(out_valid[3]),
        .cnn_output_3_TREADY(out_ready[3]),
        .cnn_output_4_TDATA (out_data[4]),
        .cnn_output_4_TVALID(out_valid[4]),
        .cnn_output_4_TREADY(out_ready[4])
    );

    // Mode 0: pixel = 160*row + col, i.e. the raster index. Mode 1: constant -1.
    function automatic logic [15:0] pix_val(input int mode, input int idx);
        return (mode == 0) ? 16'(idx) : 16'hFFFF;
    endfunction

    task automatic drive_pixels(input int mode, input int count, input bit rnd);
        int idx = 0;
        int cyc = 0;
        bit fire;
        while (idx < count && cyc < 40000) begin
            img_input_TDATA  = pix_val(mode, idx);
            img_input_TVALID = rnd ? ($urandom_range(0, 15) != 0) : 1'b1;
            @(negedge ap_clk);
            fire = img_input_TVALID && img_input_TREADY;
            @(posedge ap_clk); #1;
            if (fire) idx++;
            cyc++;
        end
        img_input_TVALID = 1'b0;
        if (idx < count) timeouts++;
    endtask

    task automatic drive_coord(input bit is_x, input logic [9:0] v, input bit rnd);
        int cyc = 0;
        bit fire = 1'b0;
        if (rnd) repeat ($urandom_range(0, 3)) begin @(posedge ap_clk); #1; end
        if (is_x) begin crop_X1_TDATA = v; crop_X1_TVALID = 1'b1; end
        else      begin crop_Y1_TDATA = v; crop_Y1_TVALID = 1'b1; end
        while (!fire && cyc < 1000) begin
            @(negedge ap_clk);
            fire = is_x ? (crop_X1_TVALID && crop_X1_TREADY) : (crop_Y1_TVALID && crop_Y1_TREADY);
            @(posedge ap_clk); #1;
            cyc++;
        end
        if (is_x) crop_X1_TVALID = 1'b0;
        else      crop_Y1_TVALID = 1'b0;
        if (!fire) timeouts++;
    endtask

    task automatic collect(input bit rnd, input int stall);
        int cyc = 0;
        int stall_left = stall;
        bit done_seen = 1'b0;
        logic [15:0] hold_val [5];
        logic [4:0] held = '0;
        for (int k = 0; k < 5; k++) begin acc_cnt[k] = 0; got_data[k] = 'x; end
        ready_cnt = 0;
        done_cnt  = 0;
        stab_err  = 0;
        while (!done_seen && cyc < 60000) begin
            for (int k = 0; k < 5; k++)
                out_ready[k] = (stall_left > 0) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            @(negedge ap_clk);
            if (|out_valid && stall_left > 0) stall_left--;
            for (int k = 0; k < 5; k++) begin
                if (out_valid[k]) begin
                    if (held[k] && out_data[k] !== hold_val[k]) stab_err++;
                    if (out_ready[k]) begin
                        got_data[k] = out_data[k];
                        acc_cnt[k]++;
                        held[k] = 1'b0;
                    end else begin
                        held[k]     = 1'b1;
                        hold_val[k] = out_data[k];
                    end
                end
            end
            if (ap_ready) ready_cnt++;
            if (ap_done) begin done_cnt++; done_seen = 1'b1; end
            @(posedge ap_clk); #1;
            cyc++;
        end
        out_ready = '0;
        if (!done_seen) timeouts++;
        @(negedge ap_clk);
        post_valid = out_valid;
        post_idle  = ap_idle;
        @(posedge ap_clk); #1;
    endtask

    task automatic run(input int mode, input logic [9:0] y1, input logic [9:0] x1,
                       input bit rnd, input int stall);
        timeouts = 0;
        ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        fork
            drive_coord(1'b0, y1, rnd);
            drive_coord(1'b1, x1, rnd);
            drive_pixels(mode, 16000, rnd);
            collect(rnd, stall);
        join
    endtask

    task automatic test_reset();
        ap_rst = 1'b1; ap_start = 1'b0;
        img_input_TVALID = 1'b0; crop_Y1_TVALID = 1'b0; crop_X1_TVALID = 1'b0;
        img_input_TDATA = '0; crop_Y1_TDATA = '0; crop_X1_TDATA = '0; out_ready = '0;
        repeat (3) @(posedge ap_clk);
        #1;
        vectors++;
        if (ap_idle !== 1'b1) begin miscompares++; $display("FAIL reset ap_idle: got %b want 1", ap_idle); end
        vectors++;
        if ({ap_done, ap_ready} !== 2'b00) begin
            miscompares++; $display("FAIL reset done/ready: got %b want 00", {ap_done, ap_ready});
        end
        vectors++;
        if ({img_input_TREADY, crop_Y1_TREADY, crop_X1_TREADY} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset treadys: got %b want 000",
                     {img_input_TREADY, crop_Y1_TREADY, crop_X1_TREADY});
        end
        vectors++;
        if (out_valid !== 5'b0) begin miscompares++; $display("FAIL reset tvalids: got %b want 0", out_valid); end
        ap_rst = 1'b0;
        @(posedge ap_clk); #1;
        vectors++;
        if (ap_idle !== 1'b1) begin miscompares++; $display("FAIL post-reset ap_idle: got %b want 1", ap_idle); end
    endtask

    task automatic test_midreset();
        ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        fork
            drive_coord(1'b0, 10'd10, 1'b0);
            drive_coord(1'b1, 10'd10, 1'b0);
            drive_pixels(0, 500, 1'b0);
        join
        vectors++;
        if (img_input_TREADY !== 1'b1) begin
            miscompares++; $display("FAIL midreset streaming: got tready %b want 1", img_input_TREADY);
        end
        #2 ap_rst = 1'b1;
        #1;
        vectors++;
        if (ap_idle !== 1'b1) begin miscompares++; $display("FAIL midreset ap_idle: got %b want 1", ap_idle); end
        vectors++;
        if ({img_input_TREADY, crop_Y1_TREADY, crop_X1_TREADY} !== 3'b000) begin
            miscompares++;
            $display("FAIL midreset treadys: got %b want 000",
                     {img_input_TREADY, crop_Y1_TREADY, crop_X1_TREADY});
        end
        vectors++;
        if ({out_valid, ap_done, ap_ready} !== 7'b0) begin
            miscompares++;
            $display("FAIL midreset valids/done/ready: got %b want 0", {out_valid, ap_done, ap_ready});
        end
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        @(posedge ap_clk); #1;
    endtask

    task automatic test_basic();
        run(0, 10'd10, 10'd10, 1'b0, 0);
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (got_data[k] !== exp_basic[k]) begin
                miscompares++;
                $display("FAIL basic out%0d: got %0d want %0d", k, $signed(got_data[k]), $signed(exp_basic[k]));
            end
        end
        vectors++;
        if (ready_cnt !== 1 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL basic pulses: got ready=%0d done=%0d want 1/1", ready_cnt, done_cnt);
        end
        vectors++;
        if (post_valid !== 5'b0 || post_idle !== 1'b1) begin
            miscompares++;
            $display("FAIL basic after done: got valid=%b idle=%b want 0/1", post_valid, post_idle);
        end
        vectors++;
        if (timeouts !== 0) begin miscompares++; $display("FAIL basic timeout: got %0d want 0", timeouts); end
    endtask

    task automatic test_random();
        run(0, 10'd10, 10'd10, 1'b1, 5000);
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (got_data[k] !== exp_basic[k] || acc_cnt[k] !== 1) begin
                miscompares++;
                $display("FAIL random out%0d: got %0d (accepted %0d times) want %0d (once)",
                         k, $signed(got_data[k]), acc_cnt[k], $signed(exp_basic[k]));
            end
        end
        vectors++;
        if (stab_err !== 0) begin miscompares++; $display("FAIL random stability: got %0d changes want 0", stab_err); end
        vectors++;
        if (ready_cnt !== 1 || done_cnt !== 1 || timeouts !== 0) begin
            miscompares++;
            $display("FAIL random pulses: got ready=%0d done=%0d timeouts=%0d want 1/1/0",
                     ready_cnt, done_cnt, timeouts);
        end
    endtask

    task automatic test_back_to_back();
        run(0, 10'd10, 10'd10, 1'b0, 0);
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (got_data[k] !== exp_basic[k]) begin
                miscompares++;
                $display("FAIL back_to_back out%0d: got %0d want %0d", k, $signed(got_data[k]), $signed(exp_basic[k]));
            end
        end
        vectors++;
        if (done_cnt !== 1 || timeouts !== 0) begin
            miscompares++; $display("FAIL back_to_back done: got %0d timeouts=%0d want 1/0", done_cnt, timeouts);
        end
    endtask

    task automatic test_clamp();
        run(0, 10'd80, 10'd150, 1'b0, 0);
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (got_data[k] !== exp_clamp[k]) begin
                miscompares++;
                $display("FAIL clamp out%0d: got %0d want %0d", k, $signed(got_data[k]), $signed(exp_clamp[k]));
            end
        end
    endtask

    task automatic test_const();
        run(1, 10'd0, 10'd0, 1'b0, 0);
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (got_data[k] !== exp_const[k]) begin
                miscompares++;
                $display("FAIL const out%0d: got %0d want %0d", k, $signed(got_data[k]), $signed(exp_const[k]));
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_midreset();
        test_basic();
        test_random();
        test_back_to_back();
        test_clamp();
        test_const();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/crop_plus_gaussian.md
Name: crop_plus_gaussian

Overview:
Streaming region-of-interest crop followed by a Gaussian-spot parameter estimator. Each run does the following:
- accepts one crop origin (Y1, X1);
- accepts a full IN_ROWS x IN_COLS raster image on an AXI-stream;
- keeps only the OUT_ROWS x OUT_COLS window;
- emits five 16-bit spot parameters, one per output stream.

It sits between the camera pixel stream and the downstream fitting/CNN stage, under an ap_ctrl_hs-style start/done wrapper.

Parameters:
- PIXEL_BIT_WIDTH, 16, signed two's-complement pixel/output width
- IN_ROWS, 100, input image rows
- IN_COLS, 160, input image columns
- OUT_ROWS, 48, crop window rows
- OUT_COLS, 48, crop window columns
- IMG_ROW_BITWIDTH, 10, width of row coordinates
- IMG_COL_BITWIDTH, 10, width of column coordinates
- SUM_SHIFT, 12, arithmetic right shift applied to the window sum

Ports:
- Interface: one clock; reset is asynchronous and active-high.
- ap_clk  in  1  clock
- ap_rst  in  1  asynchronous active-high reset
- ap_start  in  1  run request; a one-cycle pulse is sufficient
- ap_done  out  1  one-cycle pulse when all five outputs have been accepted
- ap_idle  out  1  high while in IDLE
- ap_ready  out  1  one-cycle pulse when the last image pixel is accepted
- img_input_TDATA/TVALID/TREADY  in/in/out  PIXEL_BIT_WIDTH/1/1  raster pixel stream, row-major
- crop_Y1_TDATA/TVALID/TREADY  in/in/out  IMG_ROW_BITWIDTH/1/1  crop top row
- crop_X1_TDATA/TVALID/TREADY  in/in/out  IMG_COL_BITWIDTH/1/1  crop left column
- cnn_output_k_TDATA/TVALID/TREADY, k=0..4  out/out/in  PIXEL_BIT_WIDTH/1/1  result streams

Behaviour:
- Transfer rule: a transfer occurs on a rising edge with TVALID&TREADY. The DUT samples TDATA in that same cycle.
- States: IDLE -> COORD -> STREAM -> EMIT -> IDLE.
- Reset (async, any state, including mid-run):
  - state=IDLE;
  - all TREADY=0 and all output TVALID=0;
  - ap_done=0, ap_ready=0, ap_idle=1;
  - accumulators, counters and output registers cleared to 0.
- IDLE:
  - ap_start sampled high -> COORD next cycle.
  - ap_start while not in IDLE is ignored.
- COORD:
  - crop_Y1_TREADY and crop_X1_TREADY are held high until each has transferred once. They are independent; either may arrive first.
  - Clamp: Y1 > IN_ROWS-OUT_ROWS -> Y1 = IN_ROWS-OUT_ROWS. X1 is clamped likewise against IN_COLS-OUT_COLS.
  - Both captured -> STREAM.
- STREAM:
  - img_input_TREADY=1.
  - Row/col counters advance per transfer only. TVALID gaps stall without side effects.
  - Pixel is in window iff Y1 <= row < Y1+OUT_ROWS and X1 <= col < X1+OUT_COLS.
  - In-window pixels update four quantities:
    - signed max, with relative (row-Y1, col-X1) position;
    - signed min;
    - signed sum, width PIXEL_BIT_WIDTH+12 bits.
  - Max and min use strict comparison, so ties keep the first pixel in raster order. The first in-window pixel initialises max/min.
  - On the transfer of pixel IN_ROWS*IN_COLS-1: ap_ready pulses one cycle, TREADY drops next cycle, -> EMIT.
- EMIT: all five TVALID rise together with stable TDATA. Each stream drops its TVALID independently after its own handshake. When the last one completes, ap_done pulses one cycle -> IDLE.
- Output values:
  - out0 = window max (amplitude)
  - out1 = max column relative to X1
  - out2 = max row relative to Y1
  - out3 = window min (background)
  - out4 = sum >>> SUM_SHIFT, saturated to the signed PIXEL_BIT_WIDTH range
- Backpressure: TDATA is held until the handshake, for arbitrarily long TREADY=0.
- Latency: first TVALID in the cycle after the last pixel is accepted.
- Repeated runs need no reset. A new ap_start after ap_done starts a fresh run with cleared accumulators.

Decomposition:
- Package crop_gauss_pkg holds:
  - the state enum;
  - the accumulator-width and saturation-bound localparams;
  - the output-index constants OUT_AMP=0, OUT_COL=1, OUT_ROW=2, OUT_BG=3, OUT_SUM=4.
- One natural sub-module, axis_hold_reg: a single-entry output holding register with valid/ready. It is instantiated five times.

Test Plan:
- Setup for the first three cases: pixel = 160*row+col; Y1=10, X1=10.
- Basic run, always-valid/ready: out0=9177, out1=47, out2=47, out3=1610, out4=3033. ap_ready and ap_done each pulse exactly once.
- Same image with random TVALID on all inputs and random TREADY on all outputs, including all outputs stalled 5000 cycles: identical values. Each stream is accepted exactly once and TDATA is stable while stalled.
- Same image with Y1=80, X1=150 (clamped to 52/112): out0=15999, out1=47, out2=47, out3=8432, out4=(sum 2304*160*75.5 + 2304*135.5 = 28,144,512) >>>12 = 6871.
- Constant image -1, Y1=X1=0: out0=-1, out1=0, out2=0 (tie rule), out3=-1, out4=-1.
- Assert ap_rst mid-STREAM, then start a fresh run with the basic image: all outputs idle at once, and the basic-run values are reproduced. Run three times back-to-back without reset: three identical result sets.
